serial_addsub_engine: RTL and testbench

- Bit-serial add/subtract sequencer that drives one full_adder_onebit instance (A, B, Sel, Cin in; Sum, Cout out), one bit per clock, LSB first.
- Holds the operands in shift registers, keeps the running carry in a flip-flop and assembles the WIDTH-bit result.
- The parking controller uses it to update the free-space / occupancy count: add on car entry, subtract on car exit.
- Start/Busy/Done handshake toward the controller.

---
 rtl/serial_addsub_engine.sv | 118 +++++++++++
 tb/tb_serial_addsub_engine.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_engine.sv
// rtl/serial_addsub_engine.sv - bit-serial add/subtract sequencer around a one-bit full adder

module full_adder_onebit (
    input  logic a,
    input  logic b,
    input  logic sel,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic bx;

    // sel inverts B so the same cell subtracts when carry-in starts at 1
    assign bx   = b ^ sel;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (cin & (a ^ bx));
endmodule

module serial_addsub_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [WIDTH-1:0] r_next;
    logic             op_q;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_cout;
    logic             accept, last_bit;

    full_adder_onebit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .sel  (op_q),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = start && (state != SHIFT);
    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign r_next   = {fa_sum, r_sh[WIDTH-1:1]};

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            op_q      <= 1'b0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            // carry seeded with op supplies the +1 of the two's complement
            a_sh      <= opa;
            b_sh      <= opb;
            r_sh      <= '0;
            op_q      <= op;
            carry_reg <= op;
            cnt       <= '0;
        end else if (state == SHIFT) begin
            a_sh      <= a_sh >> 1;
            b_sh      <= b_sh >> 1;
            r_sh      <= r_next;
            carry_reg <= fa_cout;
            cnt       <= cnt + 1'b1;
            if (last_bit) begin
                // carry_reg still holds the carry into the MSB here
                result   <= r_next;
                carryout <= fa_cout;
                overflow <= carry_reg ^ fa_cout;
                zero     <= (r_next == '0);
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_engine.sv
// tb/tb_serial_addsub_engine.sv - scoreboard bench for serial_addsub_engine

module tb_serial_addsub_engine;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        int           due;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] opa, opb;
    logic         busy, done;
    logic [W-1:0] result;
    logic         carryout, overflow, zero;

    exp_t q[$];
    int   cyc;
    int   tests;
    int   fails;

    serial_addsub_engine #(.WIDTH(W), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result",   int'(result),   int'(e.r));
                check("carryout", int'(carryout), int'(e.c));
                check("overflow", int'(overflow), int'(e.v));
                check("zero",     int'(zero),     int'(e.z));
                check("done_cycle", cyc, e.due);
            end
        end
    end

    // Called at a negedge just before the accepting edge
    task automatic expect_op(input logic [W-1:0] r, input logic c, input logic v, input logic z);
        exp_t e;
        e.r = r; e.c = c; e.v = v; e.z = z;
        e.due = cyc + 1 + W;
        q.push_back(e);
    endtask

    task automatic drive(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; op = ~o; opa = 8'hA5; opb = 8'h5A;
    endtask

    task automatic run(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic c, input logic v, input logic z);
        @(negedge clk);
        expect_op(r, c, v, z);
        drive(o, a, b);
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("pending_after_timeout", q.size(), 0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_outputs", int'({result, carryout, overflow, zero}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(1'b0, 8'd25,  8'd17,  8'd42,  1'b0, 1'b0, 1'b0); wait_idle();
        run(1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0); wait_idle();
        run(1'b0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0); wait_idle();
        run(1'b1, 8'd50,  8'd20,  8'd30,  1'b1, 1'b0, 1'b0); wait_idle();
        run(1'b1, 8'd20,  8'd50,  8'd226, 1'b0, 1'b0, 1'b0); wait_idle();
        run(1'b1, 8'd100, 8'd100, 8'd0,   1'b1, 1'b0, 1'b1); wait_idle();
        run(1'b1, 8'd128, 8'd1,   8'd127, 1'b1, 1'b1, 1'b0); wait_idle();

        // Start re-pulsed while busy must be ignored
        run(1'b0, 8'd25, 8'd17, 8'd42, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'd99, 8'd1);
        wait_idle();
        repeat (12) @(negedge clk);

        // Back-to-back: Start held in the Done cycle
        run(1'b0, 8'd25, 8'd17, 8'd42, 1'b0, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (!done && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("first_done_seen", int'(done), 1);
        end
        expect_op(8'd7, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'd10, 8'd3);
        check("b2b_busy", int'(busy), 1);
        check("b2b_done_low", int'(done), 0);
        wait_idle();

        // Asynchronous reset mid-operation discards the operation
        @(negedge clk);
        drive(1'b0, 8'd200, 8'd100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_outputs", int'({result, carryout, overflow, zero, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("no_done_after_reset", int'(done), 0);
        run(1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
